// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer (master) and the
// memory/datapath side (slave).
interface instr_sequencer_if;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       branch_taken;
  logic       fault_detect;
  logic       imem_req;
  logic       ir_write;
  logic [2:0] alu_op;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       pc_write;
  logic       pc_src;
  logic       trap;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  modport master (
    input  opcode, imem_ready, dmem_ready, branch_taken, fault_detect,
    output imem_req, ir_write, alu_op, mem_read, mem_write, reg_write,
           pc_write, pc_src, trap, state, fault_cnt
  );

  modport slave (
    output opcode, imem_ready, dmem_ready, branch_taken, fault_detect,
    input  imem_req, ir_write, alu_op, mem_read, mem_write, reg_write,
           pc_write, pc_src, trap, state, fault_cnt
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with fault-driven EXEC re-execution and sticky trap.
// Optional bounded retry is enabled by defining SEQ_FAULT_RETRY_EN; otherwise any EXEC fault traps.
module instr_sequencer #(
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  instr_sequencer_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [2:0] C_R  = 3'd0;
  localparam logic [2:0] C_I  = 3'd1;
  localparam logic [2:0] C_LD = 3'd2;
  localparam logic [2:0] C_ST = 3'd3;
  localparam logic [2:0] C_BR = 3'd4;

  if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_max_retry
    $error("instr_sequencer: MAX_RETRY must be within 1..7");
  end

  logic [2:0] state_q, state_d;
  logic [2:0] class_q, class_d;
  logic [7:0] fault_cnt_q, fault_cnt_d;
  logic [2:0] dec_class;
  logic       dec_legal;
  logic       exec_fault;
`ifdef SEQ_FAULT_RETRY_EN
  logic [2:0] retry_cnt_q, retry_cnt_d;
`endif

  always_comb begin
    dec_legal = 1'b1;
    dec_class = C_R;
    case (bus.opcode)
      7'b0110011: dec_class = C_R;
      7'b0010011: dec_class = C_I;
      7'b0000011: dec_class = C_LD;
      7'b0100011: dec_class = C_ST;
      7'b1100011: dec_class = C_BR;
      default:    dec_legal = 1'b0;
    endcase
  end

  assign exec_fault = (state_q == S_EXEC) && bus.fault_detect;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
`ifdef SEQ_FAULT_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif
    case (state_q)
      S_FETCH: if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        class_d = dec_class;
`ifdef SEQ_FAULT_RETRY_EN
        retry_cnt_d = 3'd0;
`endif
        state_d = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (bus.fault_detect) begin
`ifdef SEQ_FAULT_RETRY_EN
          if (retry_cnt_q < 3'(MAX_RETRY)) retry_cnt_d = retry_cnt_q + 3'd1;
          else                             state_d = S_TRAP;
`else
          state_d = S_TRAP;
`endif
        end else begin
          case (class_q)
            C_R, C_I:   state_d = S_WB;
            C_LD, C_ST: state_d = S_MEM;
            default:    state_d = S_FETCH;
          endcase
        end
      end
      S_MEM: if (bus.dmem_ready) state_d = (class_q == C_LD) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign fault_cnt_d = (exec_fault && fault_cnt_q != 8'hff) ? fault_cnt_q + 8'd1 : fault_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      class_q     <= C_R;
      fault_cnt_q <= 8'd0;
`ifdef SEQ_FAULT_RETRY_EN
      retry_cnt_q <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      fault_cnt_q <= fault_cnt_d;
`ifdef SEQ_FAULT_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  logic       imem_req, ir_write, mem_read, mem_write, reg_write, pc_write, pc_src, trap;
  logic [2:0] alu_op;

  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 3'b000;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = bus.imem_ready;
      end
      S_EXEC: begin
        case (class_q)
          C_R:     alu_op = 3'b010;
          C_I:     alu_op = 3'b011;
          C_BR:    alu_op = 3'b001;
          default: alu_op = 3'b000;
        endcase
        // A faulting branch is re-executed or trapped, so the PC must not move yet.
        if (class_q == C_BR && !bus.fault_detect) begin
          pc_write = 1'b1;
          pc_src   = bus.branch_taken;
        end
      end
      S_MEM: begin
        mem_read  = (class_q == C_LD);
        mem_write = (class_q == C_ST);
        pc_write  = (class_q == C_ST) && bus.dmem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign bus.imem_req  = imem_req;
  assign bus.ir_write  = ir_write;
  assign bus.alu_op    = alu_op;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.reg_write = reg_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.trap      = trap;
  assign bus.state     = state_q;
  assign bus.fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed table plus per-instruction generated cycle traces
// (random waits, faults, opcodes) compared cycle by cycle against the DUT.
module tb_instr_sequencer;

  localparam int MR = 2;
`ifdef SEQ_FAULT_RETRY_EN
  localparam int ALLOWED = MR;
`else
  localparam int ALLOWED = 0;
`endif

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       trap;
    logic [2:0] state;
    logic [7:0] fault_cnt;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic       fault_detect;
    logic       chk;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_sequencer_if bus();

  instr_sequencer #(.MAX_RETRY(MR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    m_fcnt = 0;
  bit    m_trap = 1'b0;
  string sect = "";
  vec_t  q[$];
  vec_t  rtab[6];

  function automatic out_t base(input logic [2:0] st);
    out_t o;
    o = '0;
    o.state = st;
    o.fault_cnt = 8'(m_fcnt);
    return o;
  endfunction

  function automatic out_t mk(input logic [2:0] st, input logic ireq, input logic irw,
                              input logic [2:0] aop, input logic rw, input logic pw, input logic ps);
    out_t o;
    o = '0;
    o.state = st; o.imem_req = ireq; o.ir_write = irw; o.alu_op = aop;
    o.reg_write = rw; o.pc_write = pw; o.pc_src = ps;
    return o;
  endfunction

  function automatic vec_t vrec(input logic [6:0] op, input logic ir, input logic dr,
                                input logic bt, input logic fd, input out_t e);
    vec_t v;
    v.rst = 1'b0; v.opcode = op; v.imem_ready = ir; v.dmem_ready = dr;
    v.branch_taken = bt; v.fault_detect = fd; v.chk = 1'b1; v.exp = e;
    return v;
  endfunction

  function automatic vec_t rnd_in();
    return vrec(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), '0);
  endfunction

  // kind: 0 = ALU writeback, 1 = load, 2 = store, 3 = branch
  function automatic bit classify(input logic [6:0] op, output logic [2:0] aop, output int kind);
    aop = 3'b000; kind = 0;
    case (op)
      OP_R:    begin aop = 3'b010; kind = 0; end
      OP_I:    begin aop = 3'b011; kind = 0; end
      OP_LD:   begin aop = 3'b000; kind = 1; end
      OP_ST:   begin aop = 3'b000; kind = 2; end
      OP_BR:   begin aop = 3'b001; kind = 3; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected trace of one instruction: iw fetch waits, dw memory waits, nf consecutive EXEC faults.
  task automatic push_instr(input logic [6:0] op, input int iw, input int dw, input int nf, input logic bt);
    vec_t v; logic [2:0] aop; int kind; bit legal;
    legal = classify(op, aop, kind);
    for (int i = 0; i < iw; i++) begin
      v = rnd_in(); v.imem_ready = 1'b0;
      v.exp = base(3'd0); v.exp.imem_req = 1'b1; q.push_back(v);
    end
    v = rnd_in(); v.imem_ready = 1'b1;
    v.exp = base(3'd0); v.exp.imem_req = 1'b1; v.exp.ir_write = 1'b1; q.push_back(v);
    v = rnd_in(); v.opcode = op; v.exp = base(3'd1); q.push_back(v);
    if (!legal) begin m_trap = 1'b1; return; end
    for (int k = 0; k < nf; k++) begin
      v = rnd_in(); v.fault_detect = 1'b1; v.exp = base(3'd2); v.exp.alu_op = aop; q.push_back(v);
      if (m_fcnt < 255) m_fcnt++;
      if (k == ALLOWED) begin m_trap = 1'b1; return; end
    end
    v = rnd_in(); v.fault_detect = 1'b0; v.branch_taken = bt;
    v.exp = base(3'd2); v.exp.alu_op = aop;
    if (kind == 3) begin v.exp.pc_write = 1'b1; v.exp.pc_src = bt; end
    q.push_back(v);
    if (kind == 3) return;
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i <= dw; i++) begin
        v = rnd_in(); v.dmem_ready = (i == dw);
        v.exp = base(3'd3); v.exp.mem_read = (kind == 1); v.exp.mem_write = (kind == 2);
        v.exp.pc_write = (kind == 2) && (i == dw);
        q.push_back(v);
      end
      if (kind == 2) return;
    end
    v = rnd_in(); v.exp = base(3'd4); v.exp.reg_write = 1'b1; v.exp.pc_write = 1'b1; q.push_back(v);
  endtask

  task automatic push_trap(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = rnd_in(); v.exp = base(3'd5); v.exp.trap = 1'b1; q.push_back(v);
    end
  endtask

  // One reset cycle at an instruction boundary or while trapped.
  task automatic push_rst();
    vec_t v;
    v = rnd_in(); v.rst = 1'b1;
    if (m_trap) begin
      v.exp = base(3'd5); v.exp.trap = 1'b1;
    end else begin
      v.exp = base(3'd0); v.exp.imem_req = 1'b1; v.exp.ir_write = v.imem_ready;
    end
    q.push_back(v);
    m_fcnt = 0; m_trap = 1'b0;
  endtask

  task automatic push_idle();
    vec_t v;
    v = rnd_in(); v.imem_ready = 1'b0; v.exp = base(3'd0); v.exp.imem_req = 1'b1; q.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    out_t act;
    rst              = v.rst;
    bus.opcode       = v.opcode;
    bus.imem_ready   = v.imem_ready;
    bus.dmem_ready   = v.dmem_ready;
    bus.branch_taken = v.branch_taken;
    bus.fault_detect = v.fault_detect;
    @(negedge clk);
    if (v.chk) begin
      act = '0;
      act.imem_req = bus.imem_req;   act.ir_write = bus.ir_write;   act.alu_op = bus.alu_op;
      act.mem_read = bus.mem_read;   act.mem_write = bus.mem_write; act.reg_write = bus.reg_write;
      act.pc_write = bus.pc_write;   act.pc_src = bus.pc_src;       act.trap = bus.trap;
      act.state = bus.state;         act.fault_cnt = bus.fault_cnt;
      n_cmp++;
      if (act !== v.exp) begin
        n_bad++;
        $display("FAIL %s[%0d]: outputs got %h expected %h", sect, idx, act, v.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string name);
    sect = name;
    for (int i = 0; i < q.size(); i++) apply(q[i], i);
    q.delete();
  endtask

  initial begin
    vec_t v;
    int   r;
    logic [6:0] op;
    logic [6:0] ops[5];

    rtab[0] = vrec(7'h00, 1'b0, 1'b1, 1'b0, 1'b1, mk(3'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    rtab[1] = vrec(7'h00, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0));
    rtab[2] = vrec(OP_R,  1'b1, 1'b1, 1'b0, 1'b0, mk(3'd1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    rtab[3] = vrec(7'h00, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd2, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0));
    rtab[4] = vrec(7'h00, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0));
    rtab[5] = vrec(7'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST; ops[4] = OP_BR;

    bus.opcode = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.fault_detect = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    sect = "rtype_table";
    for (int i = 0; i < 6; i++) apply(rtab[i], i);

    push_instr(OP_BR, 0, 0, 0, 1'b1);
    push_instr(OP_BR, 1, 0, 0, 1'b0);
    push_instr(OP_LD, 0, 3, 0, 1'b0);
    push_instr(OP_ST, 1, 1, 0, 1'b0);
    push_instr(OP_I,  2, 0, 0, 1'b0);
    run_q("directed");

`ifdef SEQ_FAULT_RETRY_EN
    push_instr(OP_R, 0, 0, 2, 1'b0);
    push_idle();
    push_instr(OP_R, 0, 0, 3, 1'b0);
`else
    push_instr(OP_R, 0, 0, 1, 1'b0);
`endif
    push_trap(3);
    push_rst();
    push_idle();
    run_q("fault_trap");

    push_instr(7'b1111111, 0, 0, 0, 1'b0);
    push_trap(2);
    push_rst();
    push_idle();
    run_q("illegal");

    // Store interrupted by reset while stalled in MEM.
    v = rnd_in(); v.imem_ready = 1'b1; v.exp = base(3'd0); v.exp.imem_req = 1'b1; v.exp.ir_write = 1'b1; q.push_back(v);
    v = rnd_in(); v.opcode = OP_ST; v.exp = base(3'd1); q.push_back(v);
    v = rnd_in(); v.fault_detect = 1'b0; v.exp = base(3'd2); q.push_back(v);
    v = rnd_in(); v.dmem_ready = 1'b0; v.exp = base(3'd3); v.exp.mem_write = 1'b1; q.push_back(v);
    v = rnd_in(); v.dmem_ready = 1'b0; v.rst = 1'b1; v.exp = base(3'd3); v.exp.mem_write = 1'b1; q.push_back(v);
    m_fcnt = 0;
    push_idle();
    run_q("store_rst");

`ifdef SEQ_FAULT_RETRY_EN
    for (int i = 0; i < 130; i++) push_instr(OP_R, 0, 0, 2, 1'b0);
    push_idle();
    run_q("saturate");
`endif

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(99);
      if (r < 6) push_rst();
      r = $urandom_range(5);
      op = (r == 5) ? 7'($urandom) : ops[r];
      push_instr(op, $urandom_range(2), $urandom_range(2),
                 ($urandom_range(9) < 7) ? 0 : $urandom_range(1, 3), 1'($urandom));
      if (m_trap) begin
        push_trap($urandom_range(1, 3));
        push_rst();
      end
    end
    run_q("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
